// File: rtl/seven_seg_multiplexer_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyphs, dark
// patterns and the sizing helper for the brightness on-window arithmetic.
package seven_seg_multiplexer_pkg;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic       ANODE_OFF = 1'b1;

    // Segment order {g,f,e,d,c,b,a}, active-low, indexed by hex value.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int unsigned on_limit_width(input int unsigned prescale,
                                                   input int unsigned dim_bits);
        return $clog2(prescale) + dim_bits + 1;
    endfunction

endpackage

// File: rtl/seven_seg_multiplexer_hex_to_seg.sv
// Hex digit to active-low seven-segment decoder with a registered output;
// a blanked request registers the all-off pattern.
module hex_to_seg
    import seven_seg_multiplexer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] hex_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_d;
    logic [6:0] seg_q;

    always_comb begin
        seg_d = SEG_OFF;
        if (!blank_i) begin
            seg_d = SEG_GLYPH[hex_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q <= SEG_OFF;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/seven_seg_multiplexer.sv
// Time-multiplexed common-anode display scanner with dimming, blanking, decimal
// points and per-frame shadowed data. Optional macro: SEG_LZ_SUPPRESS_EN.
module seven_seg_multiplexer
    import seven_seg_multiplexer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 100000,
    parameter int unsigned DIM_BITS   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [DIM_BITS-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_tick
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam int unsigned SW = $clog2(NUM_DIGITS);
    localparam int unsigned LW = on_limit_width(PRESCALE, DIM_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q, blank_q, supp_q, supp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    dp_q_out, dp_d_out;
    logic                    ft_q, ft_d;

    logic          wrap, shadow_load, in_window, lit;
    logic [LW-1:0] on_prod, on_limit;
    logic [3:0]    cur_hex;
    logic          cur_dp, cur_dark;

    assign wrap        = (cnt_q == CNT_MAX);
    assign shadow_load = !en || (wrap && (slot_q == SLOT_MAX));

    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        if (en) begin
            if (wrap) begin
                cnt_d  = '0;
                slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Brightness 0 may round the window to zero cycles; keep one lit cycle.
    always_comb begin
        on_prod  = (LW'(brightness) + LW'(1)) * LW'(PRESCALE);
        on_limit = on_prod >> DIM_BITS;
        if (on_limit == '0) begin
            on_limit = LW'(1);
        end
        in_window = (cnt_q != '0) && (LW'(cnt_q) <= on_limit);
    end

`ifdef SEG_LZ_SUPPRESS_EN
    localparam logic [NUM_DIGITS-1:0] SUPP_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    logic run;

    // Walk down from the top digit; the first non-zero or dotted digit ends it.
    always_comb begin
        supp_d = '0;
        run    = 1'b1;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            if (run && (digits_in[4*(NUM_DIGITS-k) +: 4] == 4'h0) && !dp_in[NUM_DIGITS-k]) begin
                supp_d[NUM_DIGITS-k] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end
`else
    localparam logic [NUM_DIGITS-1:0] SUPP_RST = '0;
    assign supp_d = '0;
`endif

    always_comb begin
        cur_hex  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SW'(i)) begin
                cur_hex  = digits_q[4*i +: 4];
                cur_dp   = dp_q[i];
                cur_dark = blank_q[i] | supp_q[i];
            end
        end
        lit = en && in_window && !cur_dark;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            anode_d[i] = !(lit && (slot_q == SW'(i)));
        end
        dp_d_out = !(lit && cur_dp);
        ft_d     = en && (cnt_q == '0) && (slot_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            slot_q   <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            supp_q   <= SUPP_RST;
            anode_q  <= {NUM_DIGITS{ANODE_OFF}};
            dp_q_out <= 1'b1;
            ft_q     <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            if (shadow_load) begin
                digits_q <= digits_in;
                dp_q     <= dp_in;
                blank_q  <= blank_in;
                supp_q   <= supp_d;
            end
            anode_q  <= anode_d;
            dp_q_out <= dp_d_out;
            ft_q     <= ft_d;
        end
    end

    hex_to_seg u_hex_to_seg (
        .clk_i   (clk),
        .rst_ni  (reset),
        .hex_i   (cur_hex),
        .blank_i (!en || cur_dark),
        .seg_o   (seg)
    );

    assign anode      = anode_q;
    assign dp         = dp_q_out;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seven_seg_multiplexer.sv
// Directed scoreboard bench for seven_seg_multiplexer (NUM_DIGITS=4, PRESCALE=4, DIM_BITS=2).
module tb_seven_seg_multiplexer;

    localparam int N = 4;
    localparam int P = 4;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [1:0]  brightness = '0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    typedef struct {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       chk_seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_pop = 0;

    always #5 clk = ~clk;

    seven_seg_multiplexer #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .DIM_BITS   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .brightness (brightness),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] lz_mask(input logic [15:0] digs, input logic [3:0] dps);
        logic [3:0] m;
        m = '0;
`ifdef SEG_LZ_SUPPRESS_EN
        for (int i = N - 1; i >= 1; i--) begin
            if (digs[4*i +: 4] != 4'h0 || dps[i]) break;
            m[i] = 1'b1;
        end
`else
        m = digs[3:0] & 4'h0 & dps;
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input logic [15:0] digs, input logic [3:0] dps,
                              input logic [3:0] blanks, input int b,
                              input int first, input int last);
        exp_t       e;
        int         s, c, onlim;
        logic       win, dark;
        logic [3:0] lz;
        lz    = lz_mask(digs, dps);
        onlim = ((b + 1) * P) >> D;
        if (onlim == 0) onlim = 1;
        for (int pos = first; pos <= last; pos++) begin
            s    = pos / P;
            c    = pos % P;
            dark = blanks[s] | lz[s];
            win  = (c != 0) && (c <= onlim);
            e.anode   = (win && !dark) ? ~(4'b0001 << s) : 4'hF;
            e.seg     = dark ? 7'h7F : glyph(digs[4*s +: 4]);
            e.chk_seg = dark || win;
            e.dp      = (win && !dark && dps[s]) ? 1'b0 : 1'b1;
            e.ft      = (pos == 0);
            sb.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [15:0] digs, input logic [3:0] dps,
                              input logic [3:0] blanks, input int b);
        push_range(digs, dps, blanks, b, 0, N*P - 1);
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        e.anode = 4'hF; e.seg = 7'h7F; e.chk_seg = 1'b1; e.dp = 1'b1; e.ft = 1'b0;
        repeat (n) sb.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            n_pop++;
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL scoreboard_empty@%0d: observed 0 entries expected >0", n_pop);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("anode@%0d", n_pop), 16'(anode), 16'(e.anode));
                check($sformatf("dp@%0d", n_pop), 16'(dp), 16'(e.dp));
                check($sformatf("frame_tick@%0d", n_pop), 16'(frame_tick), 16'(e.ft));
                if (e.chk_seg) check($sformatf("seg@%0d", n_pop), 16'(seg), 16'(e.seg));
            end
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_anode"}, 16'(anode), 16'hF);
        check({tag, "_seg"}, 16'(seg), 16'h7F);
        check({tag, "_dp"}, 16'(dp), 16'h1);
        check({tag, "_ft"}, 16'(frame_tick), 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with random inputs
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            digits_in  = 16'($urandom);
            dp_in      = 4'($urandom);
            blank_in   = 4'($urandom);
            brightness = 2'($urandom);
            en         = 1'($urandom);
            check_dark($sformatf("reset%0d", i));
        end

        // Release: frame 0 shows reset shadows, frame 1 the loaded data
        @(negedge clk);
        digits_in = 16'h1234; dp_in = 4'b0100; blank_in = 4'b0000; brightness = 2'd3; en = 1'b1;
        reset = 1'b1;
        push_frame(16'h0000, 4'b0000, 4'b0000, 3);
        push_frame(16'h1234, 4'b0100, 4'b0000, 3);
        run(32);

        // Dimming
        brightness = 2'd0;
        push_frame(16'h1234, 4'b0100, 4'b0000, 0);
        run(16);
        brightness = 2'd1;
        push_frame(16'h1234, 4'b0100, 4'b0000, 1);
        run(16);

        // Tear-free update during slot 1
        brightness = 2'd3;
        push_frame(16'h1234, 4'b0100, 4'b0000, 3);
        push_frame(16'hABCD, 4'b0000, 4'b0000, 3);
        run(6);
        digits_in = 16'hABCD; dp_in = 4'b0000;
        run(26);

        // Load-edge capture, leading zeros, late change waits a frame, blanking
        push_frame(16'hABCD, 4'b0000, 4'b0000, 3);
        push_frame(16'h0050, 4'b0000, 4'b0000, 3);
        push_frame(16'h0050, 4'b0000, 4'b0000, 3);
        push_frame(16'h1234, 4'b0000, 4'b0010, 3);
        run(15);
        digits_in = 16'h0050;
        run(17);
        digits_in = 16'h1234; blank_in = 4'b0010;
        run(32);

        // Mid-scan reset in slot 2
        push_frame(16'h1234, 4'b0000, 4'b0010, 3);
        run(9);
        reset = 1'b0;
        #1;
        check_dark("midreset");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        check_dark("midreset_hold");
        reset = 1'b1;
        push_frame(16'h0000, 4'b0000, 4'b0000, 3);
        push_frame(16'h1234, 4'b0000, 4'b0010, 3);
        run(32);

        // Disable for 10 cycles in slot 1; shadows track inputs while disabled
        push_range(16'h1234, 4'b0000, 4'b0010, 3, 0, 5);
        run(6);
        en = 1'b0; digits_in = 16'h9876; blank_in = 4'b0000;
        push_dark(10);
        run(10);
        en = 1'b1;
        push_range(16'h9876, 4'b0000, 4'b0000, 3, 6, 15);
        push_frame(16'h9876, 4'b0000, 4'b0000, 3);
        run(26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
